// File: rtl/parser_engine_sched.sv
// Shares a pool of parser engines between packets: round-robin dispatch on the
// input side, an order FIFO that forces PHVs back out in arrival order.
module parser_engine_sched #(
  parameter int C_NUM_ENGINES = 2,
  parameter int ENG_ID_W      = 1,
  parameter int PKT_HDR_LEN   = 1024,
  parameter int ORDER_DEPTH   = 16,
  parameter int ORDER_ADDR_W  = 4
) (
  input  logic                               axis_clk,
  input  logic                               aresetn,
  input  logic                               s_pkt_valid,
  output logic                               s_pkt_ready,
  input  logic [C_NUM_ENGINES-1:0]           engine_in_full,
  output logic [C_NUM_ENGINES-1:0]           dispatch_sel,
  input  logic [C_NUM_ENGINES-1:0]           engine_valid,
  input  logic [C_NUM_ENGINES*PKT_HDR_LEN-1:0] engine_phv,
  output logic [C_NUM_ENGINES-1:0]           engine_ready,
  input  logic                               stg_ready_in,
  output logic                               m_phv_valid,
  output logic [PKT_HDR_LEN-1:0]             m_phv,
  output logic                               order_err,
  output logic [31:0]                        pkt_in_cnt,
  output logic [31:0]                        pkt_out_cnt
);

  localparam int SW = ENG_ID_W + 1;
  localparam int CW = ORDER_ADDR_W + 1;

  logic [ENG_ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ORDER_ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ORDER_ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q, count_d;
  logic [ENG_ID_W-1:0]     order_mem_q [ORDER_DEPTH];
  logic [PKT_HDR_LEN-1:0]  m_phv_q, m_phv_d;
  logic                    m_phv_valid_q, m_phv_valid_d;
  logic                    order_err_q, order_err_d;
  logic [31:0]             pkt_in_cnt_q, pkt_in_cnt_d;
  logic [31:0]             pkt_out_cnt_q, pkt_out_cnt_d;

  logic [SW-1:0]            scan;
  logic [ENG_ID_W-1:0]      cand;
  logic                     cand_found;
  logic [C_NUM_ENGINES-1:0] cand_onehot;
  logic [C_NUM_ENGINES-1:0] head_onehot;
  logic [ENG_ID_W-1:0]      head;
  logic [PKT_HDR_LEN-1:0]   head_phv;
  logic                     fifo_full;
  logic                     fifo_nempty;
  logic                     push;
  logic                     pop;
  logic                     stray;

  assign fifo_full   = (count_q == CW'(ORDER_DEPTH));
  assign fifo_nempty = (count_q != '0);
  assign head        = order_mem_q[rd_ptr_q];

  // Scan engines starting at rr_ptr, wrapping modulo the engine count.
  always_comb begin
    scan       = '0;
    cand       = '0;
    cand_found = 1'b0;
    for (int unsigned k = 0; k < C_NUM_ENGINES; k++) begin
      scan = {1'b0, rr_ptr_q} + SW'(k);
      if (scan >= SW'(C_NUM_ENGINES)) scan = scan - SW'(C_NUM_ENGINES);
      if (!cand_found && !engine_in_full[scan[ENG_ID_W-1:0]]) begin
        cand_found = 1'b1;
        cand       = scan[ENG_ID_W-1:0];
      end
    end
  end

  always_comb begin
    cand_onehot = '0;
    head_onehot = '0;
    head_phv    = '0;
    for (int unsigned i = 0; i < C_NUM_ENGINES; i++) begin
      cand_onehot[i] = (cand == ENG_ID_W'(i));
      head_onehot[i] = fifo_nempty && (head == ENG_ID_W'(i));
      if (head == ENG_ID_W'(i)) head_phv = engine_phv[i*PKT_HDR_LEN +: PKT_HDR_LEN];
    end
  end

  // Ready is withheld during reset so nothing is dispatched into a clearing FIFO.
  assign s_pkt_ready  = aresetn & ~fifo_full & cand_found;
  assign push         = s_pkt_valid & s_pkt_ready;
  assign dispatch_sel = push ? cand_onehot : '0;
  assign engine_ready = stg_ready_in ? head_onehot : '0;
  assign pop          = |(engine_valid & head_onehot);
  assign stray        = |(engine_valid & ~head_onehot);

  always_comb begin
    rr_ptr_d      = rr_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    m_phv_d       = m_phv_q;
    m_phv_valid_d = pop;
    order_err_d   = order_err_q | stray;
    pkt_in_cnt_d  = pkt_in_cnt_q;
    pkt_out_cnt_d = pkt_out_cnt_q;
    if (push) begin
      rr_ptr_d     = (cand == ENG_ID_W'(C_NUM_ENGINES - 1)) ? '0 : cand + 1'b1;
      wr_ptr_d     = wr_ptr_q + 1'b1;
      pkt_in_cnt_d = pkt_in_cnt_q + 32'd1;
    end
    if (pop) begin
      rd_ptr_d      = rd_ptr_q + 1'b1;
      m_phv_d       = head_phv;
      pkt_out_cnt_d = pkt_out_cnt_q + 32'd1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge axis_clk) begin
    if (!aresetn) begin
      rr_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      m_phv_q       <= '0;
      m_phv_valid_q <= 1'b0;
      order_err_q   <= 1'b0;
      pkt_in_cnt_q  <= '0;
      pkt_out_cnt_q <= '0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      m_phv_q       <= m_phv_d;
      m_phv_valid_q <= m_phv_valid_d;
      order_err_q   <= order_err_d;
      pkt_in_cnt_q  <= pkt_in_cnt_d;
      pkt_out_cnt_q <= pkt_out_cnt_d;
    end
  end

  always_ff @(posedge axis_clk) begin
    if (push) order_mem_q[wr_ptr_q] <= cand;
  end

  assign m_phv       = m_phv_q;
  assign m_phv_valid = m_phv_valid_q;
  assign order_err   = order_err_q;
  assign pkt_in_cnt  = pkt_in_cnt_q;
  assign pkt_out_cnt = pkt_out_cnt_q;

endmodule

// File: tb/tb_parser_engine_sched.sv
// Directed bench for parser_engine_sched with two engines and a 16-entry order FIFO.
module tb_parser_engine_sched;

  localparam int HL = 1024;

  logic          axis_clk = 1'b0;
  logic          aresetn;
  logic          s_pkt_valid;
  logic          s_pkt_ready;
  logic [1:0]    engine_in_full;
  logic [1:0]    dispatch_sel;
  logic [1:0]    engine_valid;
  logic [2*HL-1:0] engine_phv;
  logic [1:0]    engine_ready;
  logic          stg_ready_in;
  logic          m_phv_valid;
  logic [HL-1:0] m_phv;
  logic          order_err;
  logic [31:0]   pkt_in_cnt;
  logic [31:0]   pkt_out_cnt;
  logic [HL-1:0] ph0, ph1;

  int errors = 0;
  int checks = 0;

  assign engine_phv = {ph1, ph0};

  parser_engine_sched #(
    .C_NUM_ENGINES(2), .ENG_ID_W(1), .PKT_HDR_LEN(HL), .ORDER_DEPTH(16), .ORDER_ADDR_W(4)
  ) dut (
    .axis_clk(axis_clk), .aresetn(aresetn),
    .s_pkt_valid(s_pkt_valid), .s_pkt_ready(s_pkt_ready),
    .engine_in_full(engine_in_full), .dispatch_sel(dispatch_sel),
    .engine_valid(engine_valid), .engine_phv(engine_phv), .engine_ready(engine_ready),
    .stg_ready_in(stg_ready_in), .m_phv_valid(m_phv_valid), .m_phv(m_phv),
    .order_err(order_err), .pkt_in_cnt(pkt_in_cnt), .pkt_out_cnt(pkt_out_cnt)
  );

  always #5 axis_clk = ~axis_clk;

  function automatic logic [HL-1:0] mk(input logic [31:0] t);
    return {32{t}};
  endfunction

  function automatic logic [1:0] oh(input int e);
    return (e == 0) ? 2'b01 : 2'b10;
  endfunction

  task automatic tick();
    @(posedge axis_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_phv(input string tag, input logic [31:0] t);
    logic [HL-1:0] exp;
    exp = mk(t);
    checks++;
    assert (m_phv === exp) else begin
      errors++;
      $error("FAIL %s observed_lo=%0h expected_lo=%0h", tag, m_phv[63:0], exp[63:0]);
    end
  endtask

  initial begin
    int e;
    aresetn = 1'b0; s_pkt_valid = 1'b0; engine_in_full = 2'b00;
    engine_valid = 2'b00; stg_ready_in = 1'b0; ph0 = '0; ph1 = '0;
    tick(); tick();
    chk("rst_ready", s_pkt_ready, 0);
    chk("rst_mvalid", m_phv_valid, 0);
    chk("rst_in_cnt", pkt_in_cnt, 0);
    chk("rst_out_cnt", pkt_out_cnt, 0);
    chk("rst_err", order_err, 0);
    chk("rst_eng_rdy", engine_ready, 0);
    chk_phv("rst_phv", 32'h0);

    // 1: four back-to-back packets, answered in order
    aresetn = 1'b1; stg_ready_in = 1'b1; s_pkt_valid = 1'b1; #1;
    chk("t1_ready", s_pkt_ready, 1);
    chk("t1_sel0", dispatch_sel, 2'b01);
    chk("t1_erdy_empty", engine_ready, 2'b00);
    tick(); chk("t1_sel1", dispatch_sel, 2'b10); chk("t1_erdy_h0", engine_ready, 2'b01);
    tick(); chk("t1_sel2", dispatch_sel, 2'b01);
    tick(); chk("t1_sel3", dispatch_sel, 2'b10);
    tick(); s_pkt_valid = 1'b0; #1;
    chk("t1_in_cnt", pkt_in_cnt, 4);
    chk("t1_sel_idle", dispatch_sel, 2'b00);
    engine_valid = 2'b01; ph0 = mk(32'h1000_0000); ph1 = mk(32'h1100_0000);
    tick(); chk("t1_mv0", m_phv_valid, 1); chk_phv("t1_phv0", 32'h1000_0000);
    chk("t1_erdy_h1", engine_ready, 2'b10);
    engine_valid = 2'b10; ph0 = mk(32'h1000_0001); ph1 = mk(32'h1100_0001);
    tick(); chk_phv("t1_phv1", 32'h1100_0001);
    engine_valid = 2'b01; ph0 = mk(32'h1000_0002); ph1 = mk(32'h1100_0002);
    tick(); chk_phv("t1_phv2", 32'h1000_0002);
    engine_valid = 2'b10; ph0 = mk(32'h1000_0003); ph1 = mk(32'h1100_0003);
    tick(); chk_phv("t1_phv3", 32'h1100_0003); chk("t1_mv3", m_phv_valid, 1);
    chk("t1_out_cnt", pkt_out_cnt, 4);
    engine_valid = 2'b00;
    tick(); chk("t1_mv_drop", m_phv_valid, 0); chk_phv("t1_phv_hold", 32'h1100_0003);
    chk("t1_err", order_err, 0); chk("t1_erdy_none", engine_ready, 2'b00);

    // 2: engine 0 full, three packets all go to engine 1
    stg_ready_in = 1'b0; engine_in_full = 2'b01; s_pkt_valid = 1'b1; #1;
    chk("t2_sel0", dispatch_sel, 2'b10);
    tick(); chk("t2_sel1", dispatch_sel, 2'b10);
    tick(); chk("t2_sel2", dispatch_sel, 2'b10);
    tick(); s_pkt_valid = 1'b0; engine_in_full = 2'b00; stg_ready_in = 1'b1; #1;
    chk("t2_erdy", engine_ready, 2'b10);
    engine_valid = 2'b10; ph1 = mk(32'h2100_0000);
    tick(); chk_phv("t2_phv0", 32'h2100_0000); chk("t2_erdy_b", engine_ready, 2'b10);
    tick(); chk("t2_erdy_c", engine_ready, 2'b10);
    tick(); engine_valid = 2'b00; #1;
    chk("t2_erdy_none", engine_ready, 2'b00);
    chk("t2_in_cnt", pkt_in_cnt, 7); chk("t2_out_cnt", pkt_out_cnt, 7);
    chk("t2_err", order_err, 0);

    // 3: engine 1 would be done first but must wait for head engine 0
    s_pkt_valid = 1'b1; #1;
    chk("t3_sel0", dispatch_sel, 2'b01);
    tick(); chk("t3_sel1", dispatch_sel, 2'b10);
    tick(); s_pkt_valid = 1'b0; #1;
    chk("t3_erdy_h0", engine_ready, 2'b01);
    tick(); chk("t3_erdy_wait", engine_ready, 2'b01);
    engine_valid = 2'b01; ph0 = mk(32'h3000_0000); ph1 = mk(32'h3100_0000);
    tick(); chk_phv("t3_phv0", 32'h3000_0000); chk("t3_erdy_h1", engine_ready, 2'b10);
    engine_valid = 2'b10; ph0 = mk(32'h3000_0001); ph1 = mk(32'h3100_0001);
    tick(); chk_phv("t3_phv1", 32'h3100_0001);
    engine_valid = 2'b00; #1;
    chk("t3_err", order_err, 0); chk("t3_out_cnt", pkt_out_cnt, 9);

    // 4: fill the order FIFO, then drain
    stg_ready_in = 1'b0; s_pkt_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("t4_fill_ready", s_pkt_ready, 1);
      chk("t4_fill_sel", dispatch_sel, (i % 2 == 0) ? 2'b01 : 2'b10);
      tick();
    end
    chk("t4_full_ready", s_pkt_ready, 0);
    chk("t4_full_sel", dispatch_sel, 2'b00);
    chk("t4_in_cnt16", pkt_in_cnt, 25);
    stg_ready_in = 1'b1; #1;
    chk("t4_erdy_h0", engine_ready, 2'b01);
    engine_valid = 2'b01; ph0 = mk(32'h4000_00ff); ph1 = mk(32'h4100_00ff); #1;
    chk("t4_nobypass", s_pkt_ready, 0);
    tick(); engine_valid = 2'b00; #1;
    chk("t4_ready_back", s_pkt_ready, 1);
    chk("t4_sel17", dispatch_sel, 2'b01);
    chk_phv("t4_phv_first", 32'h4000_00ff);
    tick(); s_pkt_valid = 1'b0; #1;
    chk("t4_refull", s_pkt_ready, 0);
    for (int i = 0; i < 16; i++) begin
      e = (i < 15 && i % 2 == 0) ? 1 : 0;
      engine_valid = oh(e);
      ph0 = mk(32'h4000_0000 | i); ph1 = mk(32'h4100_0000 | i); #1;
      chk("t4_drain_erdy", engine_ready, oh(e));
      tick();
      chk("t4_drain_mv", m_phv_valid, 1);
      chk_phv("t4_drain_phv", (e == 1) ? (32'h4100_0000 | i) : (32'h4000_0000 | i));
    end
    engine_valid = 2'b00; #1;
    chk("t4_erdy_none", engine_ready, 2'b00);
    chk("t4_in_cnt", pkt_in_cnt, 26); chk("t4_out_cnt", pkt_out_cnt, 26);
    chk("t4_err", order_err, 0);

    // 5: engine 1 fires while engine 0 is head
    engine_in_full = 2'b10; s_pkt_valid = 1'b1; #1;
    chk("t5_sel", dispatch_sel, 2'b01);
    tick(); s_pkt_valid = 1'b0; engine_in_full = 2'b00;
    engine_valid = 2'b10; ph1 = mk(32'h5100_0000); #1;
    chk("t5_erdy_h0", engine_ready, 2'b01);
    tick(); chk("t5_err", order_err, 1); chk("t5_no_mv", m_phv_valid, 0);
    chk("t5_head_kept", engine_ready, 2'b01); chk("t5_out_cnt", pkt_out_cnt, 26);
    engine_valid = 2'b00;
    tick(); chk("t5_err_sticky", order_err, 1);
    engine_valid = 2'b11; ph0 = mk(32'h5000_0000);
    tick(); chk("t5_both_mv", m_phv_valid, 1); chk_phv("t5_both_phv", 32'h5000_0000);
    chk("t5_both_out", pkt_out_cnt, 27);
    engine_valid = 2'b01; ph0 = mk(32'h5000_0001); #1;
    chk("t5_empty_erdy", engine_ready, 2'b00);
    tick(); chk("t5_empty_mv", m_phv_valid, 0); chk("t5_empty_out", pkt_out_cnt, 27);
    chk_phv("t5_empty_phv", 32'h5000_0000); chk("t5_err_still", order_err, 1);
    engine_valid = 2'b00;

    // 6: reset with three entries queued and rr_ptr at 1
    stg_ready_in = 1'b0; engine_in_full = 2'b10; s_pkt_valid = 1'b1; #1;
    chk("t6_sel0", dispatch_sel, 2'b01);
    tick(); engine_in_full = 2'b00; #1;
    chk("t6_sel1", dispatch_sel, 2'b10);
    tick(); chk("t6_sel2", dispatch_sel, 2'b01);
    tick(); s_pkt_valid = 1'b0; #1;
    chk("t6_in_cnt", pkt_in_cnt, 30);
    aresetn = 1'b0; #1;
    chk("t6_rst_ready", s_pkt_ready, 0);
    tick(); aresetn = 1'b1; stg_ready_in = 1'b1; #1;
    chk("t6_in_clr", pkt_in_cnt, 0); chk("t6_out_clr", pkt_out_cnt, 0);
    chk("t6_err_clr", order_err, 0); chk("t6_mv_clr", m_phv_valid, 0);
    chk_phv("t6_phv_clr", 32'h0); chk("t6_erdy_empty", engine_ready, 2'b00);
    s_pkt_valid = 1'b1; #1;
    chk("t6_sel_rr0", dispatch_sel, 2'b01);
    tick(); s_pkt_valid = 1'b0; #1;
    chk("t6_in_one", pkt_in_cnt, 1); chk("t6_erdy_h0", engine_ready, 2'b01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
